// File: rtl/clken_nco.sv
`default_nettype none
// ============================================================================
// Module   : clken_nco
// Brief    : Lock-qualified multi-channel NCO producing clock-enable pulses
//            and divided square waves from a shared reference clock.
// Revision : 1.0
// ============================================================================
module clken_nco #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 24,
    parameter int LOCK_DLY = 1024
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic [CHANNELS-1:0]       ld,
    output logic [CHANNELS-1:0]       ce,
    output logic [CHANNELS-1:0]       clkout,
    output logic                      ready
);

    localparam int                 c_cnt_w    = $clog2(LOCK_DLY + 1);
    localparam logic [c_cnt_w-1:0] c_lock_dly = c_cnt_w'(LOCK_DLY);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_lk_meta;
    logic               r_lk_s;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               r_ready;
    logic               w_run_active;

    // pll_locked is asynchronous; only r_lk_s may feed control logic
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk_s    <= r_lk_meta;
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= WAIT_LOCK;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_LOCK: begin
                if (r_lk_s) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!r_lk_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (w_cnt_inc == c_lock_dly) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!r_lk_s) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    // Counter only advances on clean SETTLE cycles; every other state holds it at 0
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == SETTLE) && r_lk_s) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_run_active = (r_state == RUN) && r_lk_s;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [ACC_W-1:0] r_inc;
            logic [ACC_W-1:0] r_acc;
            logic             r_ce;
            logic             r_clkout;
            logic [ACC_W:0]   w_sum;

            assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

            // ld outranks accumulation, so a coincident carry is dropped
            always_ff @(posedge refclk) begin
                if (rst) begin
                    r_inc    <= '0;
                    r_acc    <= '0;
                    r_ce     <= 1'b0;
                    r_clkout <= 1'b0;
                end else if (ld[gi]) begin
                    r_inc    <= inc[gi*ACC_W +: ACC_W];
                    r_acc    <= '0;
                    r_ce     <= 1'b0;
                    r_clkout <= 1'b0;
                end else if (w_run_active) begin
                    r_acc    <= w_sum[ACC_W-1:0];
                    r_ce     <= w_sum[ACC_W];
                    r_clkout <= r_clkout ^ r_ce;
                end else begin
                    r_acc    <= '0;
                    r_ce     <= 1'b0;
                    r_clkout <= 1'b0;
                end
            end

            assign ce[gi]     = r_ce;
            assign clkout[gi] = r_clkout;
        end
    endgenerate

    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_clken_nco.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for clken_nco: directed lock/load scenarios plus randomized traffic,
// with a cycle scoreboard fed by an arithmetic reference model.
module tb_clken_nco;

    localparam int CH  = 2;
    localparam int W   = 24;
    localparam int DLY = 4;

    logic          refclk     = 1'b0;
    logic          rst        = 1'b1;
    logic          pll_locked = 1'b0;
    logic [CH*W-1:0] inc      = '0;
    logic [CH-1:0] ld         = '0;
    logic [CH-1:0] ce;
    logic [CH-1:0] clkout;
    logic          ready;

    int total = 0;
    int bad   = 0;

    always #5 refclk = ~refclk;

    clken_nco #(
        .CHANNELS (CH),
        .ACC_W    (W),
        .LOCK_DLY (DLY)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .inc        (inc),
        .ld         (ld),
        .ce         (ce),
        .clkout     (clkout),
        .ready      (ready)
    );

    typedef struct packed {
        logic          rdy;
        logic [CH-1:0] ce;
        logic [CH-1:0] clk;
    } exp_t;

    exp_t q[$];

    // Reference model: running after an edge once lk_s has been seen high on
    // DLY+1 consecutive edges; ce from multiples of 2^W crossed by k*inc.
    logic            m_meta = 1'b0;
    logic            m_lks  = 1'b0;
    int              m_hi   = 0;
    bit              m_run  = 1'b0;
    longint unsigned m_inc[CH];
    longint unsigned m_k[CH];
    logic [CH-1:0]   m_ce   = '0;
    logic [CH-1:0]   m_clk  = '0;

    function automatic bit crossed(longint unsigned incv, longint unsigned k);
        return ((k * incv) >> W) != (((k - 1) * incv) >> W);
    endfunction

    always @(posedge refclk) begin
        bit   act;
        exp_t e;
        if (rst) begin
            m_meta = 1'b0;
            m_lks  = 1'b0;
            m_hi   = 0;
            m_run  = 1'b0;
            m_ce   = '0;
            m_clk  = '0;
            for (int c = 0; c < CH; c++) begin
                m_inc[c] = 0;
                m_k[c]   = 0;
            end
        end else begin
            act   = m_run && m_lks;
            m_hi  = m_lks ? m_hi + 1 : 0;
            m_run = (m_hi >= DLY + 1);
            for (int c = 0; c < CH; c++) begin
                if (ld[c]) begin
                    m_inc[c] = longint'(inc[c*W +: W]);
                    m_k[c]   = 0;
                    m_ce[c]  = 1'b0;
                    m_clk[c] = 1'b0;
                end else if (act) begin
                    m_clk[c] = m_clk[c] ^ m_ce[c];
                    m_k[c]   = m_k[c] + 1;
                    m_ce[c]  = crossed(m_inc[c], m_k[c]);
                end else begin
                    m_k[c]   = 0;
                    m_ce[c]  = 1'b0;
                    m_clk[c] = 1'b0;
                end
            end
            m_lks  = m_meta;
            m_meta = pll_locked;
        end
        e.rdy = m_run;
        e.ce  = m_ce;
        e.clk = m_clk;
        q.push_back(e);
    end

    always @(negedge refclk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({ready, ce, clkout} !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t got rdy=%b ce=%b clk=%b exp rdy=%b ce=%b clk=%b",
                         $time, ready, ce, clkout, e.rdy, e.ce, e.clk);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        int c0;
        int c1;
        logic p;
        logic [W-1:0] v;

        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_ready", int'(ready), 0);
        chk("reset_ce", int'(ce), 0);
        chk("reset_clkout", int'(clkout), 0);
        rst = 1'b0;

        // Lock-up latency and basic pulse train
        inc = {24'h155555, 24'h400000};
        ld  = 2'b11;
        cyc();
        ld = '0;
        pll_locked = 1'b1;
        cyc();
        wait_ready(n);
        chk("lock_latency", n, 6);
        r = 1;
        while (ce[0] !== 1'b1 && r < 50) begin
            cyc();
            r++;
        end
        chk("first_ce_run_cycle", r, 5);
        n = 0;
        while (clkout[0] !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        n = 0;
        do begin
            p = clkout[0];
            cyc();
            n++;
        end while (!(clkout[0] === 1'b1 && p === 1'b0) && n < 50);
        chk("clkout_period", n, 8);

        // Load coincident with the next carry of channel 0
        cyc();
        cyc();
        inc[0 +: W] = 24'h200000;
        ld = 2'b01;
        cyc();
        ld = '0;
        chk("ld_wins_ce", int'(ce[0]), 0);
        repeat (40) cyc();

        // Lock loss in RUN, then relock
        pll_locked = 1'b0;
        n = 0;
        while (ready === 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("drop_within_3", int'(n >= 1 && n <= 3), 1);
        repeat (5) cyc();
        pll_locked = 1'b1;
        cyc();
        wait_ready(n);
        chk("relock_latency", n, 6);
        repeat (30) cyc();

        // Lock glitch while settling
        pll_locked = 1'b0;
        repeat (6) cyc();
        pll_locked = 1'b1;
        repeat (3) cyc();
        pll_locked = 1'b0;
        repeat (3) cyc();
        chk("glitch_no_ready", int'(ready), 0);
        pll_locked = 1'b1;
        cyc();
        wait_ready(n);
        chk("glitch_relock_latency", n, 6);

        // Long-run rate check from a clean start
        pll_locked = 1'b0;
        repeat (4) cyc();
        inc = {24'h555556, 24'h800000};
        ld  = 2'b11;
        cyc();
        ld = '0;
        pll_locked = 1'b1;
        cyc();
        wait_ready(n);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        chk("ce0_count_3000", c0, 1500);
        chk("ce1_count_near_1000", int'(c1 >= 999 && c1 <= 1001), 1);

        // Randomized traffic
        n = 0;
        for (int i = 0; i < 2500; i++) begin
            cyc();
            rst = 1'b0;
            ld  = '0;
            if ($urandom_range(0, 99) < 6) begin
                for (int c = 0; c < CH; c++) begin
                    v = W'($urandom);
                    if ($urandom_range(0, 3) == 0) v = '0;
                    inc[c*W +: W] = v;
                end
                ld = CH'($urandom);
            end
            if (pll_locked && $urandom_range(0, 299) == 0) begin
                pll_locked = 1'b0;
                n = int'($urandom_range(1, 8));
            end else if (!pll_locked) begin
                if (n > 0) n--;
                else pll_locked = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        ld  = '0;
        pll_locked = 1'b1;
        inc = {24'h123456, 24'h0abcde};
        ld  = 2'b11;
        cyc();
        ld = '0;
        wait_ready(n);
        chk("pre_reset_running", int'(ready), 1);
        repeat (10) cyc();

        // Reset mid-RUN with load asserted
        rst = 1'b1;
        ld  = 2'b11;
        inc = {24'h7fffff, 24'h7fffff};
        cyc();
        chk("rst_ready", int'(ready), 0);
        chk("rst_ce", int'(ce), 0);
        chk("rst_clkout", int'(clkout), 0);
        rst = 1'b0;
        ld  = '0;
        wait_ready(n);
        chk("post_rst_latency", n, 7);
        c0 = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            c0 += int'(ce[0]) + int'(ce[1]);
        end
        chk("post_rst_inc_zero", c0, 0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
